// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter and the display driver.
// Provides the FSM state encoding, digit geometry and the BCD result payload.
package bcd_pkg;

  localparam int unsigned BCD_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SCRATCH_W  = BCD_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } bcd_state_t;

  // Display payload: sign plus four decimal digits, most significant first.
  typedef struct packed {
    logic               negative;
    logic [DIGIT_W-1:0] thousands;
    logic [DIGIT_W-1:0] hundreds;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_result_t;

endpackage : bcd_pkg

// File: rtl/bcd_converter_if.sv
// Request/result bundle between the SPI capture logic and the BCD converter.
// master: drives sample/in_valid, observes status and digits.
// slave : the converter; receives the request, drives busy/done/negative/digits.
interface bcd_converter_if #(
  parameter int unsigned W = 12
);
  import bcd_pkg::*;

  logic [W-1:0]       sample;
  logic               in_valid;
  logic               busy;
  logic               done;
  logic               negative;
  logic [DIGIT_W-1:0] thousands;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;

  modport master (
    output sample, in_valid,
    input  busy, done, negative, thousands, hundreds, tens, ones
  );

  modport slave (
    input  sample, in_valid,
    output busy, done, negative, thousands, hundreds, tens, ones
  );

endinterface : bcd_converter_if

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more so
// the following left shift carries correctly into the next decimal digit.
// Ports: nibble (4-bit BCD digit in), adj_c (corrected digit, combinational).
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble,
  output logic [DIGIT_W-1:0] adj_c
);

  always_comb begin
    adj_c = nibble;
    if (nibble >= DIGIT_W'(5)) begin
      adj_c = nibble + DIGIT_W'(3);
    end
  end

endmodule : bcd_add3

// File: rtl/bcd_converter.sv
// Sequential signed binary to sign + 4-digit BCD converter (one bit per clock).
// Ports: clk, reset (synchronous, active-high),
//        bus (slave): sample/in_valid request in; busy, done pulse,
//        negative and thousands..ones digits out.
// Latency from accept to done is W+1 cycles; digit outputs change only on LOAD.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic            clk,
  input  logic            reset,
  bcd_converter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(W + 1);
  localparam int unsigned SR_W  = SCRATCH_W + W;

  bcd_state_t state_q, state_d;

  logic [SCRATCH_W-1:0] scratch_q, scratch_d;
  logic [SCRATCH_W-1:0] scratch_adj_c;
  logic [W-1:0]         mag_q, mag_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_cap_q, neg_cap_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  bcd_result_t          result_q, result_d;

  logic [W-1:0]         sample_c;
  logic [W-1:0]         mag_in_c;
  logic [SR_W-1:0]      shift_c;

  // Magnitude of the incoming sample; the most negative value maps to 2^(W-1).
  assign sample_c = W'(bus.sample);
  assign mag_in_c = sample_c[W-1] ? (~sample_c + W'(1)) : sample_c;

  // Per-digit add-3 correction on the scratch register ahead of each shift.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .adj_c  (scratch_adj_c[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shift_c = {scratch_adj_c, mag_q} << 1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only accepted in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-values.
  always_comb begin
    scratch_d = scratch_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    neg_cap_d = neg_cap_q;
    result_d  = result_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag_d     = mag_in_c;
          neg_cap_d = sample_c[W-1];
          scratch_d = '0;
          cnt_d     = CNT_W'(W);
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        scratch_d = shift_c[SR_W-1 -: SCRATCH_W];
        mag_d     = shift_c[W-1:0];
        cnt_d     = cnt_q - CNT_W'(1);
        busy_d    = 1'b1;
      end
      LOAD: begin
        result_d.negative  = neg_cap_q;
        result_d.thousands = scratch_q[3*DIGIT_W +: DIGIT_W];
        result_d.hundreds  = scratch_q[2*DIGIT_W +: DIGIT_W];
        result_d.tens      = scratch_q[1*DIGIT_W +: DIGIT_W];
        result_d.ones      = scratch_q[0 +: DIGIT_W];
        done_d             = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      neg_cap_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      neg_cap_q <= neg_cap_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.negative  = result_q.negative;
  assign bus.thousands = result_q.thousands;
  assign bus.hundreds  = result_q.hundreds;
  assign bus.tens      = result_q.tens;
  assign bus.ones      = result_q.ones;

endmodule : bcd_converter

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter (W=12): reset state, directed samples,
// dropped requests while busy/LOAD, reset mid-conversion, full-range sweep.
module tb_bcd_converter;

  localparam int unsigned W = 12;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bcd_converter_if #(.W(W)) bus ();

  bcd_converter #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {negative, thousands, hundreds, tens, ones} as observed on the bus.
  function automatic int obs();
    return {15'd0, bus.negative, bus.thousands, bus.hundreds, bus.tens, bus.ones};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input int s);
    bus.sample   = W'(s);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Edges counted from the accept edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input int s, input int exp);
    int lat;
    accept(s);
    check({tag, "_busy"}, int'(bus.busy), 1);
    wait_done(lat);
    check({tag, "_lat"}, lat, 13);
    check({tag, "_val"}, obs(), exp);
    check({tag, "_busy_low"}, int'(bus.busy), 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(bus.done), 0);
  endtask

  initial begin
    int lat;
    int dones;
    int base;
    int max_dig;
    int s, m, e, o;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.sample   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_digits", obs(), 'h00000);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    reset = 1'b0;

    // Directed values, expected digits written as hex-coded BCD.
    run_vec("zero",  0,     'h00000);
    run_vec("p1234", 1234,  'h01234);
    run_vec("m2048", -2048, 'h12048);
    run_vec("p2047", 2047,  'h02047);
    run_vec("m1",    -1,    'h10001);

    // Requests in cycle 3 (SHIFT) and cycle 13 (LOAD) must be dropped.
    bus.sample   = W'(1234);
    bus.in_valid = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
      bus.sample   = W'(-5);
      bus.in_valid = (cyc == 3 || cyc == 13 || cyc == 14);
      if (cyc < 14) @(posedge clk);
    end
    check("drop_done_count", dones, 1);
    check("drop_val", obs(), 'h01234);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("drop_next_busy", int'(bus.busy), 1);
    wait_done(lat);
    check("drop_next_lat", lat, 13);
    check("drop_next_val", obs(), 'h10005);
    @(posedge clk);
    @(negedge clk);

    // Reset in cycle 6 of a conversion clears outputs and suppresses done.
    run_vec("p999", 999, 'h00999);
    bus.sample   = W'(1500);
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (cyc == 6) reset = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("midrst_digits", obs(), 'h00000);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_vec("p1500", 1500, 'h01500);

    // Every 12-bit value once, back-to-back at full rate, permuted order.
    base    = done_cnt;
    max_dig = 0;
    for (int i = 0; i < 4096; i++) begin
      s = (i * 1237 + 311) % 4096;
      if (s >= 2048) s = s - 4096;
      accept(s);
      wait_done(lat);
      check("sweep_lat", lat, 13);
      m = (s < 0) ? -s : s;
      e = ((s < 0) ? 1 : 0) << 16;
      e = e | ((m / 1000) << 12) | (((m / 100) % 10) << 8) |
          (((m / 10) % 10) << 4) | (m % 10);
      o = obs();
      if (lat < 0) $display("FAIL sweep_timeout sample %0d got none expected done", s);
      if (o !== e) $display("FAIL sweep_val sample %0d got %0h expected %0h", s, o, e);
      n_checks++;
      if (o !== e) n_errors++;
      for (int d = 0; d < 4; d++) begin
        if (((o >> (4 * d)) & 'hF) > max_dig) max_dig = (o >> (4 * d)) & 'hF;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("sweep_done_count", done_cnt - base, 4096);
    check("sweep_max_digit_le9", int'(max_dig <= 9), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_bcd_converter
